// File: rtl/iic_tgt_pkg.sv
// Shared types and constants for the I2C target register block.
package iic_tgt_pkg;

  localparam int unsigned IIC_CNT_W = 4;
  localparam logic [IIC_CNT_W-1:0] IIC_ACK_IDX = 4'd8;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    WDATA,
    RDATA,
    IGNORE
  } iic_tgt_state_t;

endpackage

// File: rtl/iic_line_cond.sv
// Line conditioner: 2-FF synchronizer, optional 3-sample majority filter
// (IIC_TGT_FILTER_EN), and rise/fall edge strobes. Lines idle high.
module iic_line_cond (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[0], pin};
  end

`ifdef IIC_TGT_FILTER_EN
  logic [2:0] hist_q;
  logic       filt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '1;
      filt_q <= 1'b1;
    end else begin
      hist_q <= {hist_q[1:0], sync_q[1]};
      filt_q <= (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
    end
  end

  assign level = filt_q;
`else
  assign level = sync_q[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= level;
  end

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

endmodule

// File: rtl/iic_target_regs.sv
// I2C target with a 2**REG_AW byte register file, auto-incrementing pointer
// and a fabric write-report port. Optional line filter: IIC_TGT_FILTER_EN.
module iic_target_regs
  import iic_tgt_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h2B,
  parameter int unsigned REG_AW  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iic_scl,
  inout  wire               iic_sda,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              wr_valid,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  localparam int unsigned DEPTH = 2 ** REG_AW;
  localparam logic [IIC_CNT_W-1:0] LAST_BIT = IIC_ACK_IDX - 1'b1;
  localparam logic [IIC_CNT_W-1:0] ACK_END  = IIC_ACK_IDX + 1'b1;

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start, stop;

  iic_line_cond u_scl (.clk(clk), .rst(rst), .pin(iic_scl),
                       .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));
  iic_line_cond u_sda (.clk(clk), .rst(rst), .pin(iic_sda),
                       .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));

  assign start = sda_fall & scl_lvl;
  assign stop  = sda_rise & scl_lvl;

  iic_tgt_state_t        state_q, state_d;
  logic [IIC_CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]            shreg_q, shreg_d;
  logic [REG_AW-1:0]     ptr_q, ptr_d;
  logic                  sda_oe_q, sda_oe_d;
  logic                  busy_q, busy_d;
  logic                  we;
  logic [7:0]            wbyte;
  logic [7:0]            regs_q [DEPTH];

  assign iic_sda = sda_oe_q ? 1'b0 : 1'bz;
  assign rd_data = regs_q[rd_addr];
  assign busy    = busy_q;
  assign wbyte   = {shreg_q[6:0], sda_lvl};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    ptr_d    = ptr_q;
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    we       = 1'b0;
    if (stop) begin
      state_d  = IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start) begin
      state_d  = ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        ADDR: if (scl_rise) begin
          shreg_d = wbyte;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            if (shreg_q[6:0] == DEV_ADDR) begin
              state_d = ADDR_ACK;
              busy_d  = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_rise && cnt_q == IIC_ACK_IDX) cnt_d = ACK_END;
          if (scl_fall && cnt_q == IIC_ACK_IDX) sda_oe_d = 1'b1;
          if (scl_fall && cnt_q == ACK_END) begin
            cnt_d = '0;
            // R/W bit is still in shreg[0]; a read drives its MSB on this same fall
            if (shreg_q[0]) begin
              state_d  = RDATA;
              shreg_d  = regs_q[ptr_q];
              sda_oe_d = ~regs_q[ptr_q][7];
            end else begin
              state_d  = PTR;
              sda_oe_d = 1'b0;
            end
          end
        end
        PTR, WDATA: begin
          if (scl_rise && cnt_q < IIC_ACK_IDX) begin
            shreg_d = wbyte;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
              if (state_q == PTR) begin
                ptr_d = wbyte[REG_AW-1:0];
              end else begin
                we    = 1'b1;
                ptr_d = ptr_q + 1'b1;
              end
            end
          end
          if (scl_rise && cnt_q == IIC_ACK_IDX) cnt_d = ACK_END;
          if (scl_fall && cnt_q == IIC_ACK_IDX) sda_oe_d = 1'b1;
          if (scl_fall && cnt_q == ACK_END) begin
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            state_d  = WDATA;
          end
        end
        RDATA: begin
          if (scl_rise && cnt_q < IIC_ACK_IDX) cnt_d = cnt_q + 1'b1;
          if (scl_rise && cnt_q == IIC_ACK_IDX) begin
            if (!sda_lvl) begin
              ptr_d = ptr_q + 1'b1;
              cnt_d = ACK_END;
            end else begin
              state_d = IGNORE;
            end
          end
          if (scl_fall) begin
            if (cnt_q != '0 && cnt_q < IIC_ACK_IDX) begin
              shreg_d  = {shreg_q[6:0], 1'b0};
              sda_oe_d = ~shreg_q[6];
            end else if (cnt_q == IIC_ACK_IDX) begin
              sda_oe_d = 1'b0;
            end else if (cnt_q == ACK_END) begin
              cnt_d    = '0;
              shreg_d  = regs_q[ptr_q];
              sda_oe_d = ~regs_q[ptr_q][7];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      ptr_q    <= '0;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      ptr_q    <= ptr_d;
      sda_oe_q <= sda_oe_d;
      busy_q   <= busy_d;
      wr_valid <= we;
      if (we) begin
        wr_addr <= ptr_q;
        wr_data <= wbyte;
      end
      // committing from the reported write keeps rd_data one cycle behind wr_valid
      if (wr_valid) regs_q[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_iic_target_regs.sv
// Bench for iic_target_regs: bit-banged I2C initiator with scoreboard queues.
module tb_iic_target_regs;

  localparam int unsigned Q = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       tb_sda_low = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  wire        iic_sda;

  pullup (iic_sda);
  assign iic_sda = tb_sda_low ? 1'b0 : 1'bz;

  iic_target_regs #(.DEV_ADDR(7'h2B), .REG_AW(4)) dut (
    .clk(clk), .rst(rst), .iic_scl(scl), .iic_sda(iic_sda),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  exp_q [$];
  logic [11:0] wr_q [$];
  logic [7:0]  model_regs [16];
  logic [3:0]  model_ptr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (wr_valid) begin
      if (wr_q.size() == 0) chk("wr_unexpected", {31'd0, wr_valid}, 32'd0);
      else chk("wr_commit", {20'd0, wr_addr, wr_data}, {20'd0, wr_q.pop_front()});
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // one bit slot, entered and left with SCL low
  task automatic clk_bit(input logic drive_low, input logic glitch, output logic s);
    wait_clks(Q);
    tb_sda_low = drive_low;
    wait_clks(Q / 2);
    if (glitch) begin
      scl = 1'b1;
      @(negedge clk);
      scl = 1'b0;
    end
    wait_clks(Q / 2);
    scl = 1'b1;
    wait_clks(Q);
    s = iic_sda;
    wait_clks(Q);
    scl = 1'b0;
  endtask

  task automatic i2c_start();
    tb_sda_low = 1'b1;
    wait_clks(2 * Q);
    scl = 1'b0;
  endtask

  task automatic i2c_rstart();
    wait_clks(Q);
    tb_sda_low = 1'b0;
    wait_clks(Q);
    scl = 1'b1;
    wait_clks(Q);
    tb_sda_low = 1'b1;
    wait_clks(Q);
    scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clks(Q);
    tb_sda_low = 1'b1;
    wait_clks(Q);
    scl = 1'b1;
    wait_clks(Q);
    tb_sda_low = 1'b0;
    wait_clks(2 * Q);
  endtask

  task automatic send(input logic [7:0] b, input logic exp_nack, input int unsigned glitch_at = 99);
    logic s;
    exp_q.push_back({7'd0, exp_nack});
    for (int unsigned i = 0; i < 8; i++) clk_bit(~b[7-i], (i == glitch_at), s);
    clk_bit(1'b0, 1'b0, s);
    chk("ack_bit", {24'd0, 7'd0, s}, {24'd0, exp_q.pop_front()});
  endtask

  task automatic recv(input logic nack);
    logic       s;
    logic [7:0] b;
    exp_q.push_back(model_regs[model_ptr]);
    b = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      clk_bit(1'b0, 1'b0, s);
      b = {b[6:0], s};
    end
    clk_bit(~nack, 1'b0, s);
    chk("rd_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
    if (!nack) model_ptr++;
  endtask

  task automatic put_ptr(input logic [7:0] p, input int unsigned glitch_at = 99);
    model_ptr = p[3:0];
    send(p, 1'b0, glitch_at);
  endtask

  task automatic put_data(input logic [7:0] d, input int unsigned glitch_at = 99);
    wr_q.push_back({model_ptr, d});
    model_regs[model_ptr] = d;
    model_ptr++;
    send(d, 1'b0, glitch_at);
  endtask

  task automatic chk_reg(input logic [3:0] a);
    rd_addr = a;
    #1;
    chk("rd_data", {24'd0, rd_data}, {24'd0, model_regs[a]});
  endtask

  initial begin
    logic s;
    foreach (model_regs[i]) model_regs[i] = '0;
    model_ptr = '0;
    wait_clks(4);
    chk("rst_sda", {31'd0, iic_sda}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    chk("rst_wr_word", {20'd0, wr_addr, wr_data}, 32'd0);
    for (int unsigned a = 0; a < 16; a++) chk_reg(4'(a));
    rst = 1'b0;
    wait_clks(4);

    // single-byte write at 3
    i2c_start();
    send(8'h56, 1'b0);
    chk("busy_on", {31'd0, busy}, 32'd1);
    put_ptr(8'h03);
    put_data(8'hA5);
    i2c_stop();
    chk("busy_off", {31'd0, busy}, 32'd0);
    chk_reg(4'd3);

    // pointer write, repeated START, 2-byte read
    i2c_start();
    send(8'h56, 1'b0);
    put_ptr(8'h03);
    i2c_rstart();
    send(8'h57, 1'b0);
    recv(1'b0);
    recv(1'b1);
    wait_clks(Q / 2);
    chk("sda_after_nack", {31'd0, iic_sda}, 32'd1);
    i2c_stop();

    // wrong address
    i2c_start();
    send(8'h50, 1'b1);
    chk("busy_wrong_addr", {31'd0, busy}, 32'd0);
    send(8'h12, 1'b1);
    i2c_stop();

    // burst across the top of the file, then read back through the wrap
    i2c_start();
    send(8'h56, 1'b0);
    put_ptr(8'hFE);
    put_data(8'h11);
    put_data(8'h22);
    put_data(8'h33);
    i2c_stop();
    chk_reg(4'd14);
    chk_reg(4'd15);
    chk_reg(4'd0);
    i2c_start();
    send(8'h56, 1'b0);
    put_ptr(8'h0E);
    i2c_rstart();
    send(8'h57, 1'b0);
    recv(1'b0);
    recv(1'b0);
    recv(1'b1);
    i2c_stop();

    // reset while the target drives a read bit
    i2c_start();
    send(8'h56, 1'b0);
    put_ptr(8'h05);
    i2c_rstart();
    send(8'h57, 1'b0);
    for (int unsigned i = 0; i < 4; i++) clk_bit(1'b0, 1'b0, s);
    wait_clks(Q);
    scl = 1'b1;
    wait_clks(Q / 2);
    chk("rd_bit5_driven", {31'd0, iic_sda}, 32'd0);
    #2 rst = 1'b1;
    #1 chk("rst_sda_release", {31'd0, iic_sda}, 32'd1);
    foreach (model_regs[i]) model_regs[i] = '0;
    model_ptr = '0;
    wait_clks(3);
    chk("rst_busy_mid", {31'd0, busy}, 32'd0);
    chk_reg(4'd3);
    rst = 1'b0;
    wait_clks(2);
    scl = 1'b0;
    i2c_stop();
    i2c_start();
    send(8'h56, 1'b0);
    put_ptr(8'h02);
    put_data(8'h77);
    i2c_stop();
    chk_reg(4'd2);

`ifdef IIC_TGT_FILTER_EN
    i2c_start();
    send(8'h56, 1'b0);
    put_ptr(8'h08);
    put_data(8'h5A, 3);
    i2c_stop();
    chk_reg(4'd8);
`endif

    wait_clks(10);
    chk("wr_pending", wr_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
